// File: rtl/fx_mac_pipe.sv
// Two-stage fixed-point ADD/SUB/MUL/MAC unit with saturating result and accumulator.
// Stage 1 registers the raw arithmetic value; stage 2 accumulates, clamps and presents the result.
module fx_mac_pipe #(
   parameter int SIGN         = 1,
   parameter int WIDTH        = 8,
   parameter int FP_POSITIONS = 4,
   parameter int ACC_WIDTH    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             acc_clear,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   // Internal width holds any sum, shifted product or accumulator sum without wrap.
   localparam int XW = ((ACC_WIDTH > 2*WIDTH) ? ACC_WIDTH : 2*WIDTH) + 2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MAC = 2'b11;

   localparam logic signed [XW-1:0] ONE    = XW'(1);
   localparam logic signed [XW-1:0] RES_HI = (SIGN != 0) ? (ONE <<< (WIDTH-1)) - ONE
                                                         : (ONE <<< WIDTH) - ONE;
   localparam logic signed [XW-1:0] RES_LO = (SIGN != 0) ? -(ONE <<< (WIDTH-1)) : '0;
   localparam logic signed [XW-1:0] ACC_HI = (SIGN != 0) ? (ONE <<< (ACC_WIDTH-1)) - ONE
                                                         : (ONE <<< ACC_WIDTH) - ONE;
   localparam logic signed [XW-1:0] ACC_LO = (SIGN != 0) ? -(ONE <<< (ACC_WIDTH-1)) : '0;

   function automatic logic signed [XW-1:0] ext_w(input logic [WIDTH-1:0] v);
      return {{(XW-WIDTH){(SIGN != 0) & v[WIDTH-1]}}, v};
   endfunction

   function automatic logic signed [XW-1:0] ext_acc(input logic [ACC_WIDTH-1:0] v);
      return {{(XW-ACC_WIDTH){(SIGN != 0) & v[ACC_WIDTH-1]}}, v};
   endfunction

   logic                  s1_valid, s2_valid;
   logic [1:0]            s1_op;
   logic                  s1_clr;
   logic signed [XW-1:0]  s1_raw;
   logic [ACC_WIDTH-1:0]  acc;

   logic                  s2_free, accept, s2_load;
   logic signed [XW-1:0]  a_x, b_x, prod, raw_d;
   logic signed [XW-1:0]  base, acc_sum, acc_sat, res_src, res_sat;
   logic                  is_mac, acc_ovf, res_ovf;
   logic [ACC_WIDTH-1:0]  acc_d;
   logic [WIDTH-1:0]      res_d;
   logic                  ovf_d;

   assign s2_free   = !s2_valid | out_ready;
   assign in_ready  = !s1_valid | s2_free;
   assign accept    = in_valid & in_ready;
   assign s2_load   = s1_valid & s2_free;
   assign out_valid = s2_valid;

   always_comb begin
      a_x  = ext_w(a);
      b_x  = ext_w(b);
      prod = a_x * b_x;
      // Unsigned products stay non-negative in XW, so the arithmetic shift acts as a logical one.
      case (op)
         OP_ADD:  raw_d = a_x + b_x;
         OP_SUB:  raw_d = a_x - b_x;
         default: raw_d = prod >>> FP_POSITIONS;
      endcase
   end

   always_comb begin
      is_mac  = (s1_op == OP_MAC);
      base    = s1_clr ? '0 : ext_acc(acc);
      acc_sum = base + s1_raw;
      acc_ovf = (acc_sum > ACC_HI) || (acc_sum < ACC_LO);
      acc_sat = (acc_sum > ACC_HI) ? ACC_HI : ((acc_sum < ACC_LO) ? ACC_LO : acc_sum);
      acc_d   = is_mac ? ACC_WIDTH'(acc_sat) : (s1_clr ? '0 : acc);
      res_src = is_mac ? acc_sat : s1_raw;
      res_ovf = (res_src > RES_HI) || (res_src < RES_LO);
      res_sat = (res_src > RES_HI) ? RES_HI : ((res_src < RES_LO) ? RES_LO : res_src);
      res_d   = WIDTH'(res_sat);
      ovf_d   = res_ovf | (is_mac & acc_ovf);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_clr   <= 1'b0;
         s1_raw   <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op    <= op;
         s1_clr   <= acc_clear;
         s1_raw   <= raw_d;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // acc moves only on a stage-2 load so stalls never re-accumulate a beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         acc      <= '0;
         result   <= '0;
         overflow <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         acc      <= acc_d;
         result   <= res_d;
         overflow <= ovf_d;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fx_mac_pipe.sv
// Directed bench for fx_mac_pipe: latency, saturation, MAC streams, stalls, unsigned mode, reset.
module tb_fx_mac_pipe;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] MUL = 2'b10;
   localparam logic [1:0] MAC = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       acc_clear = 1'b0;
   logic [1:0] op = 2'b00;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;

   logic       in_ready, out_valid, overflow;
   logic [7:0] result;
   logic       in_ready_u, out_valid_u, overflow_u;
   logic [7:0] result_u;

   int checks = 0;
   int passes = 0;

   logic [1:0] s_op  [5] = '{ADD,   MUL,   MUL,   MUL,   ADD};
   logic [7:0] s_a   [5] = '{8'h70, 8'hF0, 8'hFF, 8'h7F, 8'h80};
   logic [7:0] s_b   [5] = '{8'h20, 8'h08, 8'h08, 8'h7F, 8'h80};
   logic [7:0] s_res [5] = '{8'h7F, 8'hF8, 8'hFF, 8'h7F, 8'h80};
   logic       s_ovf [5] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
   logic [7:0] e_mac [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

   fx_mac_pipe #(.SIGN(1), .WIDTH(8), .FP_POSITIONS(4), .ACC_WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .acc_clear(acc_clear), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .overflow(overflow)
   );

   fx_mac_pipe #(.SIGN(0), .WIDTH(8), .FP_POSITIONS(4), .ACC_WIDTH(16)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .op(op),
      .acc_clear(acc_clear), .a(a), .b(b), .out_valid(out_valid_u), .out_ready(out_ready),
      .result(result_u), .overflow(overflow_u)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, input logic c);
      in_valid  = v;
      op        = o;
      a         = aa;
      b         = bb;
      acc_clear = c;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      int beat;
      int k;

      #1;
      chk("rst_out_valid", 16'(out_valid), 16'h0);
      chk("rst_result",    16'(result),    16'h0);
      chk("rst_overflow",  16'(overflow),  16'h0);
      chk("rst_in_ready",  16'(in_ready),  16'h1);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // MUL 1.5 * 2.0 with exact two-cycle latency
      drive(1'b1, MUL, 8'h18, 8'h20, 1'b0);
      tick();
      chk("lat_c1_valid", 16'(out_valid), 16'h0);
      drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
      tick();
      chk("lat_c2_valid", 16'(out_valid), 16'h1);
      chk("lat_result",   16'(result),    16'h30);
      chk("lat_overflow", 16'(overflow),  16'h0);
      tick();
      chk("lat_c3_valid", 16'(out_valid), 16'h0);

      // Saturation and rounding stream at full throughput
      for (int i = 0; i < 7; i++) begin
         if (i >= 2) begin
            chk("sat_valid",  16'(out_valid), 16'h1);
            chk("sat_result", 16'(result),    16'(s_res[i-2]));
            chk("sat_ovf",    16'(overflow),  16'(s_ovf[i-2]));
         end
         if (i < 5) drive(1'b1, s_op[i], s_a[i], s_b[i], 1'b0);
         else       drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
         tick();
      end

      // Back-to-back MAC, clear on first beat
      for (int i = 0; i < 6; i++) begin
         if (i >= 2) begin
            chk("mac_valid",  16'(out_valid), 16'h1);
            chk("mac_result", 16'(result),    16'(e_mac[i-2]));
            chk("mac_ovf",    16'(overflow),  16'h0);
         end
         if (i < 4) drive(1'b1, MAC, 8'h10, 8'h10, i == 0);
         else       drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
         tick();
      end
      chk("mac_drain", 16'(out_valid), 16'h0);

      // Same MAC stream with downstream stalled for the first three cycles
      beat = 0;
      k    = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         out_ready = (cyc >= 3);
         if (beat < 4) drive(1'b1, MAC, 8'h10, 8'h10, beat == 0);
         else          drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
         #1;
         if (cyc == 2) begin
            chk("stall_in_ready", 16'(in_ready),  16'h0);
            chk("stall_hold_v",   16'(out_valid), 16'h1);
            chk("stall_hold_r",   16'(result),    16'h10);
         end
         if (out_valid && out_ready) begin
            chk("stall_result", 16'(result), 16'(e_mac[k & 3]));
            k++;
         end
         if (in_valid && in_ready) beat++;
         tick();
      end
      chk("stall_emits",   16'(k),    16'd4);
      chk("stall_accepts", 16'(beat), 16'd4);
      out_ready = 1'b1;

      // SUB underflow: signed gives -1.0, unsigned clamps to zero
      drive(1'b1, SUB, 8'h10, 8'h20, 1'b0);
      tick();
      drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
      tick();
      chk("sub_s_result", 16'(result),      16'hF0);
      chk("sub_s_ovf",    16'(overflow),    16'h0);
      chk("sub_u_valid",  16'(out_valid_u), 16'h1);
      chk("sub_u_result", 16'(result_u),    16'h00);
      chk("sub_u_ovf",    16'(overflow_u),  16'h1);
      tick();

      // Reset in the middle of a MAC stream
      drive(1'b1, MAC, 8'h10, 8'h10, 1'b1);
      tick();
      drive(1'b1, MAC, 8'h10, 8'h10, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
      #1;
      chk("mid_rst_valid",    16'(out_valid), 16'h0);
      chk("mid_rst_result",   16'(result),    16'h0);
      chk("mid_rst_in_ready", 16'(in_ready),  16'h1);
      tick();
      rst = 1'b0;
      tick();
      drive(1'b1, MAC, 8'h10, 8'h10, 1'b0);
      tick();
      drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
      tick();
      chk("post_rst_valid",  16'(out_valid), 16'h1);
      chk("post_rst_result", 16'(result),    16'h10);
      chk("post_rst_ovf",    16'(overflow),  16'h0);
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
